mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch (IF) and data access (MEM stage).
- Runs one outstanding transaction at a time through an FSM. Emits per-requester stall signals that the hazard detection unit ORs into its stall/flush decisions.
- Data side has priority. A bounded-burst counter guarantees IF forward progress.
- Sits between the pipeline stage logic and the memory bus wrapper.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DM_BURST, 4, maximum consecutive DM grants while if_req is pending (range 1..15)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  IF read request; held until if_done
- if_addr  in  ADDR_W  fetch address
- if_kill  in  1  IF flush from the hazard unit; discards the pending/outstanding IF result
- if_done  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- dm_req  in  1  DM request; held until dm_done
- dm_we  in  1  1 = write
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_wstrb  in  4  byte enables
- dm_done  out  1  one-cycle pulse: access complete, dm_rdata valid for reads
- dm_rdata  out  DATA_W  load data
- if_stall  out  1  if_req & ~if_done
- dm_stall  out  1  dm_req & ~dm_done
- mem_req  out  1  memory request, held until mem_gnt
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/DATA_W/4  latched request fields, stable while mem_req=1
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  response (read data or write ack); never earlier than the cycle after mem_gnt
- mem_rdata  in  DATA_W  read data

Behaviour:
- Reset values: all outputs 0, state IDLE, owner=IF, burst counter 0, kill flag 0. A reset assertion mid-transaction aborts it immediately, with no done pulse.
- FSM has four states: IDLE, REQ, WAIT, DONE.
- IDLE, arbitration:
  - If dm_req=1 and (if_req=0 or burst_cnt<MAX_DM_BURST), pick DM.
  - Otherwise, if if_req=1 and if_kill=0, pick IF.
  - On a pick, latch owner and all request fields, then go to REQ.
- REQ: mem_req=1. On mem_gnt, go to WAIT.
- WAIT: on mem_rvalid, capture mem_rdata into the owner's rdata register and go to DONE.
- DONE: raise the owner's done pulse for exactly one cycle, then go to IDLE. A requester is never re-arbitrated during its DONE cycle.
- Minimum latency (req high in cycle 0, gnt in cycle 1, rvalid in cycle 2): done in cycle 3; the next arbitration happens in cycle 4.
- Burst counter:
  - Increments on each DM pick made while if_req=1, saturating at MAX_DM_BURST.
  - Clears on any IF pick, or on a DM pick made with if_req=0.
- if_kill:
  - While owner=IF in REQ or WAIT, set the kill flag. The memory transaction still completes, since the bus cannot be aborted.
  - At DONE with the kill flag set, suppress if_done and clear the flag.
  - if_kill in IDLE blocks an IF pick that cycle.
  - if_kill has no effect when owner=DM.
- if_rdata and dm_rdata hold their values until the next capture for the same owner.
- Simultaneous events:
  - dm_req and if_req rising in the same cycle: DM wins unless the burst limit is reached.
  - if_kill and mem_rvalid in the same cycle: the result is discarded.
- Requesters must not change their addr/data fields while req=1. The arbiter uses latched copies regardless.

Test Plan:
- Single IF read: if_req=1, if_addr=0x100; mem_gnt in cycle 1, mem_rvalid with rdata 0x00500093 in cycle 2 -> mem_addr=0x100, if_done=1 and if_rdata=0x00500093 in cycle 3; if_stall=1 in cycles 0–2.
- Conflict: if_req and dm_req (read of 0x2000) both high in cycle 0 -> DM served first (dm_done in cycle 3), IF picked in cycle 4, if_done in cycle 7 with 1-cycle memory; if_stall stays high throughout.
- Starvation bound: dm_req held continuously with new addresses and if_req held, MAX_DM_BURST=4 -> exactly 4 dm_done pulses, then one if_done, then the DM grants resume.
- Flush mid-fetch: IF owner in WAIT, if_kill pulsed, memory stalls rvalid 3 cycles -> no if_done; FSM returns to IDLE; a subsequent if_req to 0x200 completes normally.
- Write: dm_we=1, addr 0x3004, wdata 0xDEADBEEF, wstrb 0x3 -> mem_we=1 and mem_wstrb=0x3 held through a 2-cycle gnt delay; dm_done pulses once after the ack.
- Reset abort: rst_n low while in WAIT -> all outputs 0 asynchronously; after release, a stale mem_rvalid produces no done pulse, and the next request is served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port unified memory between instruction fetch (IF) and
// the data-memory stage (DM). One transaction is outstanding at a time and
// is walked through a four-state FSM: IDLE -> REQ -> WAIT -> DONE -> IDLE.
// The data side wins arbitration. A burst counter caps how many DM grants
// can go back to back while IF is waiting, so IF always makes progress.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   if_req/if_addr/if_kill         fetch request, address, and flush
//   if_done/if_rdata               one-cycle completion pulse and data
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_wstrb              data request and fields
//   dm_done/dm_rdata               one-cycle completion pulse and load data
//   if_stall/dm_stall              per-requester stall to the hazard unit
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wstrb            latched request towards the bus wrapper
//   mem_gnt                        bus accepted the request this cycle
//   mem_rvalid/mem_rdata           response (read data or write ack)

module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DM_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  // data memory side
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [3:0]        dm_wstrb,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  // to the hazard unit
  output logic              if_stall,
  output logic              dm_stall,
  // memory bus
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_e;
  typedef enum logic       {OWN_IF, OWN_DM} owner_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
  } req_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_DM_BURST);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  req_t              req_q, req_d;
  logic [3:0]        burst_q, burst_d;
  logic              kill_q, kill_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic pick_dm, pick_if;
  logic if_owns_bus;

  // DM wins unless IF is waiting and DM has used up its burst allowance.
  // A flush in the same cycle cancels the fetch before it is ever issued.
  assign pick_dm = dm_req & (~if_req | (burst_q < BURST_MAX));
  assign pick_if = ~pick_dm & if_req & ~if_kill;

  // IF holds the bus in REQ/WAIT; a flush there can only be remembered,
  // because the bus transaction itself cannot be withdrawn.
  assign if_owns_bus = (owner_q == OWN_IF) &&
                       ((state_q == ST_REQ) || (state_q == ST_WAIT));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    req_d      = req_q;
    burst_d    = burst_q;
    kill_d     = kill_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    if (if_owns_bus && if_kill) kill_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (pick_dm) begin
          owner_d = OWN_DM;
          req_d   = '{we: dm_we, addr: dm_addr, wdata: dm_wdata, wstrb: dm_wstrb};
          // Only grants that actually make IF wait count against the burst.
          if (if_req) begin
            if (burst_q < BURST_MAX) burst_d = burst_q + 4'd1;
          end else begin
            burst_d = '0;
          end
          state_d = ST_REQ;
        end else if (pick_if) begin
          owner_d = OWN_IF;
          req_d   = '{we: 1'b0, addr: if_addr, wdata: '0, wstrb: '0};
          burst_d = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          if (owner_q == OWN_IF) if_rdata_d = mem_rdata;
          else                   dm_rdata_d = mem_rdata;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // The flag only lives for the transaction it was raised on.
        kill_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      req_q      <= '0;
      burst_q    <= '0;
      kill_q     <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      req_q      <= req_d;
      burst_q    <= burst_d;
      kill_q     <= kill_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Outputs are decoded from registered state only, so they all drop the
  // moment reset asserts. Stalls are additionally gated by reset so the
  // hazard unit sees a quiet arbiter while it is held in reset.
  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_wstrb = req_q.wstrb;

  assign if_done   = (state_q == ST_DONE) && (owner_q == OWN_IF) && !kill_q;
  assign dm_done   = (state_q == ST_DONE) && (owner_q == OWN_DM);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

  assign if_stall  = rst_n & if_req & ~if_done;
  assign dm_stall  = rst_n & dm_req & ~dm_done;

endmodule
